// File: rtl/alu_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module : alu_test_pkg
//  Shared definitions for the ALU self-test sequencer: FSM state encoding,
//  default MISR polynomial, opcode width and MISR seed.
//  Revision: 1.0 - initial release
// ============================================================================
package alu_test_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_A   = 4'd1,
    S_CAP_A  = 4'd2,
    S_RD_B   = 4'd3,
    S_CAP_B  = 4'd4,
    S_RD_OP  = 4'd5,
    S_CAP_OP = 4'd6,
    S_SAMPLE = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  localparam logic [31:0] c_default_poly  = 32'h04C11DB7;
  localparam int          c_op_w          = 6;
  // Every MISR bit is seeded with this value (all-ones seed).
  localparam logic        c_misr_seed_bit = 1'b1;

endpackage : alu_test_pkg
`default_nettype wire

// File: rtl/alu_test_misr.sv
`default_nettype none
// ============================================================================
//  Module : alu_test_misr
//  Multiple-input signature register. Each step computes
//    sig <= (sig << 1) ^ (sig[MSB] ? POLY : 0) ^ d
//  Ports:
//    clk, reset_n   clock / asynchronous active-low reset (sig -> 0)
//    i_load         load the all-ones seed (priority over i_step)
//    i_step         fold i_d into the signature
//    i_d            data word to compress
//    o_sig          current signature
//    o_sig_next     value the signature takes on the next step
//  Revision: 1.0 - initial release
// ============================================================================
module alu_test_misr
  import alu_test_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [31:0] POLY  = c_default_poly
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_sig,
  output logic [WIDTH-1:0] o_sig_next
);

  localparam logic [WIDTH-1:0] c_poly = WIDTH'(POLY);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_next;

  assign w_next = {r_sig[WIDTH-2:0], 1'b0}
                ^ (r_sig[WIDTH-1] ? c_poly : '0)
                ^ i_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sig <= '0;
    end else if (i_load) begin
      r_sig <= {WIDTH{c_misr_seed_bit}};
    end else if (i_step) begin
      r_sig <= w_next;
    end
  end

  assign o_sig      = r_sig;
  assign o_sig_next = w_next;

endmodule : alu_test_misr
`default_nettype wire

// File: rtl/alu_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : alu_test_sequencer
//  Self-test engine for the ALU: sweeps every operand pair of the operand ROM
//  against every opcode of the opcode ROM, drives the ALU with each vector,
//  compresses result + N/Z/V/C into a MISR and compares with gold_sig.
//  Build option: ALU_TEST_CIN_SWEEP_EN - run each vector with cin=0 then
//  cin=1; otherwise cin is cin_cfg sampled at start.
//  Ports:
//    clk, reset_n            clock / asynchronous active-low reset
//    start, abort            sweep request / synchronous abort
//    cin_cfg, gold_sig       carry-in (no sweep) / expected signature
//    val_addr, val_data      operand ROM (data valid one cycle after addr)
//    op_addr, op_data        opcode ROM  (data valid one cycle after addr)
//    alu_op/a/b/cin          registered ALU stimulus
//    alu_res/n/z/v/c         combinational ALU response
//    busy, done, pass        status; done is a one-cycle pulse
//    sig, vec_count          signature and saturating vector count
//  Revision: 1.0 - initial release
// ============================================================================
module alu_test_sequencer
  import alu_test_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          N_PAIRS = 5,
  parameter int          N_OPS   = 23,
  parameter logic [31:0] POLY    = c_default_poly,
  localparam int         AW_V    = $clog2(2 * N_PAIRS),
  localparam int         AW_O    = (N_OPS > 1) ? $clog2(N_OPS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cin_cfg,
  input  logic [WIDTH-1:0]  gold_sig,
  output logic [AW_V-1:0]   val_addr,
  input  logic [WIDTH-1:0]  val_data,
  output logic [AW_O-1:0]   op_addr,
  input  logic [c_op_w-1:0] op_data,
  output logic [c_op_w-1:0] alu_op,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_cin,
  input  logic [WIDTH-1:0]  alu_res,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_c,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [WIDTH-1:0]  sig,
  output logic [15:0]       vec_count
);

  localparam int PW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

  state_t            r_state;
  logic [PW-1:0]     r_p;
  logic [AW_O-1:0]   r_k;
  logic              r_cin_sel;
  logic [AW_V-1:0]   r_val_addr;
  logic [AW_O-1:0]   r_op_addr;
  logic [c_op_w-1:0] r_alu_op;
  logic [WIDTH-1:0]  r_alu_a;
  logic [WIDTH-1:0]  r_alu_b;
  logic              r_alu_cin;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [15:0]       r_vec_count;

  logic              w_cin_first;  // cin for the first pass of a vector
  logic              w_cin_more;   // another cin pass of this vector remains
  logic              w_cin_after;  // cin selection once the vector is finished
  logic              w_last_op;
  logic              w_last_pair;
  logic              w_load;
  logic              w_sample;
  logic [WIDTH-1:0]  w_misr_d;
  logic [WIDTH-1:0]  w_sig_next;

`ifdef ALU_TEST_CIN_SWEEP_EN
  logic w_unused_cin_cfg;
  assign w_unused_cin_cfg = cin_cfg;
  assign w_cin_first      = 1'b0;
  assign w_cin_more       = ~r_cin_sel;
  assign w_cin_after      = 1'b0;
`else
  assign w_cin_first      = cin_cfg;
  assign w_cin_more       = 1'b0;
  assign w_cin_after      = r_cin_sel;
`endif

  assign w_last_op   = (int'(r_k) == N_OPS - 1);
  assign w_last_pair = (int'(r_p) == N_PAIRS - 1);
  assign w_load      = (r_state == S_IDLE) && start;
  // An abort landing on SAMPLE leaves the signature and count untouched.
  assign w_sample    = (r_state == S_SAMPLE) && !abort;
  assign w_misr_d    = alu_res ^ {{(WIDTH-4){1'b0}}, alu_n, alu_z, alu_v, alu_c};

  alu_test_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_step     (w_sample),
    .i_d        (w_misr_d),
    .o_sig      (sig),
    .o_sig_next (w_sig_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_p         <= '0;
      r_k         <= '0;
      r_cin_sel   <= 1'b0;
      r_val_addr  <= '0;
      r_op_addr   <= '0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_cin   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_vec_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort && r_busy) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_p         <= '0;
              r_k         <= '0;
              r_cin_sel   <= w_cin_first;
              r_vec_count <= '0;
              r_val_addr  <= '0;
              r_busy      <= 1'b1;
              r_state     <= S_RD_A;
            end
          end
          S_RD_A:  r_state <= S_CAP_A;
          S_CAP_A: begin
            r_alu_a    <= val_data;
            r_val_addr <= AW_V'({r_p, 1'b1});
            r_state    <= S_RD_B;
          end
          S_RD_B:  r_state <= S_CAP_B;
          S_CAP_B: begin
            r_alu_b   <= val_data;
            r_op_addr <= r_k;
            r_state   <= S_RD_OP;
          end
          S_RD_OP: r_state <= S_CAP_OP;
          S_CAP_OP: begin
            r_alu_op  <= op_data;
            r_alu_cin <= r_cin_sel;
            r_state   <= S_SAMPLE;
          end
          S_SAMPLE: begin
            if (r_vec_count != 16'hFFFF) begin
              r_vec_count <= r_vec_count + 16'd1;
            end
            if (w_cin_more) begin
              r_cin_sel <= 1'b1;
              r_op_addr <= r_k;
              r_state   <= S_RD_OP;
            end else if (!w_last_op) begin
              r_cin_sel <= w_cin_after;
              r_k       <= r_k + 1'b1;
              r_op_addr <= r_k + 1'b1;
              r_state   <= S_RD_OP;
            end else if (!w_last_pair) begin
              r_cin_sel  <= w_cin_after;
              r_k        <= '0;
              r_p        <= r_p + 1'b1;
              r_val_addr <= AW_V'({r_p + 1'b1, 1'b0});
              r_state    <= S_RD_A;
            end else begin
              // Compare against the signature this step produces, so pass
              // is valid in the same cycle as the done pulse.
              r_pass  <= (w_sig_next == gold_sig);
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign val_addr  = r_val_addr;
  assign op_addr   = r_op_addr;
  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_cin   = r_alu_cin;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign vec_count = r_vec_count;

endmodule : alu_test_sequencer
`default_nettype wire

// File: tb/tb_alu_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : tb_alu_test_sequencer
//  Self-checking bench: a default-size sequencer (5 pairs x 23 ops) and a
//  single-vector sequencer, each with its own synchronous ROMs and a small
//  combinational ALU model. Build option ALU_TEST_CIN_SWEEP_EN is honoured.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_alu_test_sequencer;

  localparam int NP = 5;
  localparam int NO = 23;
  localparam logic [31:0] POLY = 32'h04C11DB7;
`ifdef ALU_TEST_CIN_SWEEP_EN
  localparam int CF = 2;  localparam bit SWEEP = 1'b1;
  localparam int EXP_VECS = 230, EXP_CYC = 711, EXP1_VECS = 2, EXP1_CYC = 11;
  localparam logic [31:0] S1_SIG = 32'hF2BCD93C;
`else
  localparam int CF = 1;  localparam bit SWEEP = 1'b0;
  localparam int EXP_VECS = 115, EXP_CYC = 366, EXP1_VECS = 1, EXP1_CYC = 8;
  localparam logic [31:0] S1_SIG = 32'hFB3EE241;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // main DUT
  logic m_start, m_abort, m_cin_cfg, m_busy, m_done, m_pass, m_alu_cin;
  logic m_n, m_z, m_v, m_c;
  logic [31:0] m_gold, m_val_data, m_alu_a, m_alu_b, m_res, m_sig;
  logic [3:0]  m_val_addr;
  logic [4:0]  m_op_addr;
  logic [5:0]  m_op_data, m_alu_op;
  logic [15:0] m_vec;
  // single-vector DUT
  logic s_start, s_abort, s_cin_cfg, s_busy, s_done, s_pass, s_alu_cin;
  logic s_n, s_z, s_v, s_c;
  logic [31:0] s_gold, s_val_data, s_alu_a, s_alu_b, s_res, s_sig;
  logic [0:0]  s_val_addr, s_op_addr;
  logic [5:0]  s_op_data, s_alu_op;
  logic [15:0] s_vec;

  logic [31:0] vrom [16];
  logic [5:0]  orom [32];
  logic [31:0] vrom1 [2];
  logic [5:0]  orom1 [2];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [35:0] alu_model(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
    logic [32:0] t; logic [31:0] r; logic c, v;
    c = 1'b0; v = 1'b0; t = '0;
    case (op[2:0])
      3'd0: begin t = {1'b0, a} + {1'b0, b} + {32'b0, cin}; r = t[31:0]; c = t[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin t = {1'b0, a} - {1'b0, b} - {32'b0, cin}; r = t[31:0]; c = t[32];
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a & ~b;
      3'd6: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    if (op[3]) r = ~r;
    if (op[4]) r = {r[15:0], r[31:16]};
    return {r, r[31], (r == 32'd0), v, c};
  endfunction

  assign {m_res, m_n, m_z, m_v, m_c} = alu_model(m_alu_op, m_alu_a, m_alu_b, m_alu_cin);
  assign {s_res, s_n, s_z, s_v, s_c} = alu_model(s_alu_op, s_alu_a, s_alu_b, s_alu_cin);

  always @(posedge clk) begin
    m_val_data <= vrom[m_val_addr];
    m_op_data  <= orom[m_op_addr];
    s_val_data <= vrom1[s_val_addr];
    s_op_data  <= orom1[s_op_addr];
  end

  alu_test_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(m_start), .abort(m_abort), .cin_cfg(m_cin_cfg),
    .gold_sig(m_gold), .val_addr(m_val_addr), .val_data(m_val_data), .op_addr(m_op_addr),
    .op_data(m_op_data), .alu_op(m_alu_op), .alu_a(m_alu_a), .alu_b(m_alu_b),
    .alu_cin(m_alu_cin), .alu_res(m_res), .alu_n(m_n), .alu_z(m_z), .alu_v(m_v),
    .alu_c(m_c), .busy(m_busy), .done(m_done), .pass(m_pass), .sig(m_sig), .vec_count(m_vec)
  );

  alu_test_sequencer #(.WIDTH(32), .N_PAIRS(1), .N_OPS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(s_start), .abort(s_abort), .cin_cfg(s_cin_cfg),
    .gold_sig(s_gold), .val_addr(s_val_addr), .val_data(s_val_data), .op_addr(s_op_addr),
    .op_data(s_op_data), .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b),
    .alu_cin(s_alu_cin), .alu_res(s_res), .alu_n(s_n), .alu_z(s_z), .alu_v(s_v),
    .alu_c(s_c), .busy(s_busy), .done(s_done), .pass(s_pass), .sig(s_sig), .vec_count(s_vec)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference signature of the first 'limit' vectors of the main sweep.
  function automatic logic [31:0] ref_sig(input logic cfg, input int limit);
    logic [31:0] s; logic [35:0] r; logic cin; int j;
    s = 32'hFFFFFFFF; j = 0;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < NO; k++)
        for (int cc = 0; cc < CF; cc++) begin
          cin = SWEEP ? (cc == 1) : cfg;
          r = alu_model(orom[k], vrom[2*p], vrom[2*p+1], cin);
          if (j < limit)
            s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'd0) ^ (r[35:4] ^ {28'd0, r[3:0]});
          j++;
        end
    return s;
  endfunction

  task automatic run_main(input bit pulse, input logic cfg, input logic flip,
                          output int cyc, output bit got_done);
    int prev, j, p, k; logic ecin;
    m_cin_cfg = cfg;
    m_gold    = ref_sig(cfg, 100000) ^ {31'd0, flip};
    m_start   = 1'b1;
    tick(); cyc = 1; m_start = 1'b0;
    check("seed_sig", m_sig, 32'hFFFFFFFF);
    check("seed_count", m_vec, 0);
    check("busy_after_start", m_busy, 1);
    prev = 0; got_done = 1'b0;
    while (!got_done && cyc < 3000) begin
      if (int'(m_vec) != prev) begin
        j = prev;
        p = j / (NO * CF);
        k = (j % (NO * CF)) / CF;
        ecin = SWEEP ? ((j % CF) == 1) : cfg;
        check("stimulus", {m_alu_op, m_alu_cin, m_alu_a, m_alu_b},
              {orom[k], ecin, vrom[2*p], vrom[2*p+1]});
        prev = int'(m_vec);
      end
      if (m_done) got_done = 1'b1;
      else begin
        m_start = pulse && (cyc == 7);  // cycle 7 is SAMPLE of vector 0
        tick(); cyc++;
      end
    end
    m_start = 1'b0;
  endtask

  typedef struct {
    bit   pulse;
    logic cfg;
    logic flip;
    int   exp_vec;
    int   exp_cyc;
    logic exp_pass;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int cyc; bit got; bit saw;
    tbl[0] = '{1'b0, 1'b0, 1'b0, EXP_VECS, EXP_CYC, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b0, EXP_VECS, EXP_CYC, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, EXP_VECS, EXP_CYC, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, EXP_VECS, EXP_CYC, 1'b1};

    for (int i = 0; i < 16; i++) vrom[i] = 32'd0;
    vrom[0] = 32'h00000005; vrom[1] = 32'h00000003;
    vrom[2] = 32'hFFFFFFFF; vrom[3] = 32'h00000001;
    vrom[4] = 32'h80000000; vrom[5] = 32'h80000000;
    vrom[6] = 32'h7FFFFFFF; vrom[7] = 32'h0000001F;
    vrom[8] = 32'h12345678; vrom[9] = 32'hA5A5F00F;
    for (int i = 0; i < 32; i++) orom[i] = 6'((i * 5 + 1) % 64);
    vrom1[0] = 32'd5; vrom1[1] = 32'd3;
    orom1[0] = 6'd0;  orom1[1] = 6'd0;

    m_start = 0; m_abort = 0; m_cin_cfg = 0; m_gold = 0;
    s_start = 0; s_abort = 0; s_cin_cfg = 0; s_gold = S1_SIG;
    reset_n = 1'b0;
    tick(); tick();
    check("reset_busy", m_busy, 0);
    check("reset_sig", m_sig, 0);
    check("reset_count", m_vec, 0);
    check("reset_done_pass", {m_done, m_pass}, 0);
    reset_n = 1'b1;
    tick();

    // single-vector sweep
    s_start = 1'b1; tick(); cyc = 1; s_start = 1'b0;
    while (!s_done && cyc < 200) begin tick(); cyc++; end
    check("single_cycles", cyc, EXP1_CYC);
    check("single_count", s_vec, EXP1_VECS);
    check("single_sig", s_sig, S1_SIG);
    check("single_pass", s_pass, 1);

    // table-driven full sweeps
    for (int i = 0; i < 4; i++) begin
      run_main(tbl[i].pulse, tbl[i].cfg, tbl[i].flip, cyc, got);
      check("done_seen", got, 1);
      check("sweep_cycles", cyc, tbl[i].exp_cyc);
      check("sweep_count", m_vec, tbl[i].exp_vec);
      check("sweep_sig", m_sig, ref_sig(tbl[i].cfg, 100000));
      check("sweep_pass", m_pass, tbl[i].exp_pass);
      check("busy_at_done", m_busy, 0);
      tick();
      check("done_one_cycle", m_done, 0);
      tick();
    end

    // abort 20 cycles into a sweep
    m_cin_cfg = 1'b0;
    m_start = 1'b1; tick(); m_start = 1'b0;
    repeat (19) tick();
    m_abort = 1'b1; tick(); m_abort = 1'b0;
    check("abort_busy", m_busy, 0);
    check("abort_count", m_vec, 5);
    check("abort_sig", m_sig, ref_sig(1'b0, 5));
    saw = 1'b0;
    repeat (10) begin
      if (m_done) saw = 1'b1;
      tick();
    end
    check("abort_no_done", saw, 0);
    check("abort_pass_kept", m_pass, tbl[3].exp_pass);
    check("abort_count_hold", m_vec, 5);
    run_main(1'b0, 1'b0, 1'b0, cyc, got);
    check("restart_cycles", cyc, EXP_CYC);
    check("restart_sig", m_sig, ref_sig(1'b0, 100000));
    tick(); tick();

    // asynchronous reset mid-sweep
    m_start = 1'b1; tick(); m_start = 1'b0;
    repeat (29) tick();
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_sig", m_sig, 0);
    check("rst_mid_count", m_vec, 0);
    check("rst_mid_status", {m_busy, m_done, m_pass}, 0);
    check("rst_mid_addr", {m_val_addr, m_op_addr}, 0);
    check("rst_mid_stim", {m_alu_op, m_alu_a, m_alu_b, m_alu_cin}, 0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    check("rst_release_idle", {m_busy, m_done}, 0);
    run_main(1'b0, 1'b0, 1'b0, cyc, got);
    check("rst_sweep_cycles", cyc, EXP_CYC);
    check("rst_sweep_count", m_vec, EXP_VECS);
    check("rst_sweep_sig", m_sig, ref_sig(1'b0, 100000));
    check("rst_sweep_pass", m_pass, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_alu_test_sequencer
`default_nettype wire

// File: doc/alu_test_sequencer.md
# alu_test_sequencer

- Synthesizable, parametrised self-test engine for the SPARC V8 ALU.
- Sweeps every stored operand pair against every stored opcode and drives the ALU with each combination. Compresses each result and its N/Z/V/C flags into a MISR signature, then compares that signature with a golden value.
- Sits beside the `alu` instance and replaces file-driven simulation stimulus, so the same sweep runs in silicon/FPGA and in regression.

## Interface
Parameters:
- `WIDTH`, 32 — operand/result width; must be ≥ 8.
- `N_PAIRS`, 5 — number of (a,b) operand pairs in the operand ROM; must be ≥ 1.
- `N_OPS`, 23 — number of 6-bit opcodes in the opcode ROM; must be ≥ 1.
- `POLY`, 32'h04C11DB7 — MISR feedback polynomial; only the low `WIDTH` bits are used.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1 — clock, rising edge.
- `reset_n` in 1 — asynchronous active-low reset.
- `start` in 1 — single-cycle request to begin a sweep.
- `abort` in 1 — synchronous abort.
- `cin_cfg` in 1 — carry-in used when the Cin sweep is compiled out.
- `gold_sig` in WIDTH — expected final signature.
- `val_addr` out AW_V=max(1,$clog2(2*N_PAIRS)) — operand ROM address; a is at 2p, b is at 2p+1.
- `val_data` in WIDTH — operand ROM data, valid the cycle after `val_addr`.
- `op_addr` out AW_O=max(1,$clog2(N_OPS)) — opcode ROM address.
- `op_data` in 6 — opcode ROM data, valid the cycle after `op_addr`.
- `alu_op` out 6 — registered ALU stimulus.
- `alu_a` out WIDTH — registered ALU stimulus.
- `alu_b` out WIDTH — registered ALU stimulus.
- `alu_cin` out 1 — registered ALU stimulus.
- `alu_res` in WIDTH — ALU result; the ALU is combinational.
- `alu_n` in 1 — ALU N flag.
- `alu_z` in 1 — ALU Z flag.
- `alu_v` in 1 — ALU V flag.
- `alu_c` in 1 — ALU C flag.
- `busy` out 1 — a sweep is in progress.
- `done` out 1 — one-cycle pulse at sweep end.
- `pass` out 1 — `sig == gold_sig`, registered at DONE.
- `sig` out WIDTH — running/final MISR signature.
- `vec_count` out 16 — vectors sampled, saturating at 16'hFFFF.

## Operation
FSM states: IDLE, RD_A, CAP_A, RD_B, CAP_B, RD_OP, CAP_OP, SAMPLE, DONE.

- **IDLE:** on `start`, clear `vec_count`, load `sig` with all-ones, p=0, k=0, c=0, then go to RD_A. `start` in any other state is ignored.
- **RD_A / RD_B:** drive `val_addr` to 2p / 2p+1.
- **CAP_A / CAP_B:** latch `val_data` into `alu_a` / `alu_b`.
- **RD_OP:** drive `op_addr` = k.
- **CAP_OP:** latch `op_data` into `alu_op` and set `alu_cin`.
- **SAMPLE:** fold the ALU outputs into the MISR and increment `vec_count`:
  - d = `alu_res` ^ {0…, N, Z, V, C} (flags in bits 3:0);
  - `sig` ← (`sig` << 1) ^ (`sig`[W-1] ? POLY : 0) ^ d.
- **Sequencing out of SAMPLE:**
  - next Cin pass if applicable → RD_OP;
  - else k+1 < N_OPS → RD_OP;
  - else p+1 < N_PAIRS → RD_A, with k=0;
  - else → DONE.
- **DONE:**
  - `done`=1 and `pass` is updated for exactly one cycle;
  - `busy` is 0 in this state;
  - next state is IDLE.
- **`abort`:** in any busy state, go to IDLE next cycle. `sig` and `vec_count` hold their values, `done` is not pulsed and `pass` is unchanged.
- **`reset_n` low:** takes effect immediately, including mid-sweep.
  - All outputs go to 0: `sig`, `vec_count`, `pass`, `done`, `busy`, addresses, and ALU stimulus.
  - The FSM goes to IDLE.

## Timing
- `busy`=1 from the cycle after `start` is accepted through SAMPLE of the last vector.
- Cycles per vector: 3 (RD_OP, CAP_OP, SAMPLE). Pair overhead: 4 cycles.
- Total cycles from the `start` edge to the `done` cycle: N_PAIRS·(4 + 3·N_OPS·C) + 1, where C=2 with the Cin sweep and C=1 without it.
- The ALU is sampled one cycle after its stimulus registers update, allowing one full cycle of combinational ALU path.
- `vec_count` saturates and never wraps. `sig` updates only in SAMPLE.

## Configuration
- `ALU_TEST_CIN_SWEEP_EN` defined: each (pair, opcode) runs twice, first with `alu_cin`=0 and then `alu_cin`=1. `cin_cfg` is unused.
- Not defined: each vector runs once with `alu_cin` = `cin_cfg`, sampled at `start`.

## Structure
- Package `alu_test_pkg` holds:
  - FSM state enum;
  - default POLY;
  - opcode width constant (6);
  - MISR seed constant (all-ones).
- Sub-module `alu_test_misr` (WIDTH, POLY): inputs `load`, `step`, d; output `sig`. Isolates the signature arithmetic for reuse in other unit self-tests.

## Test plan
- **Reset:** assert `reset_n`=0 mid-sweep → every output reads 0 in the same cycle; the FSM is in IDLE after release; the next `start` runs a full, clean sweep.
- **Single-vector sweep** (N_PAIRS=1, N_OPS=1, W=32, Cin sweep off; ROM a=5, b=3, op=6'b000000; bench ALU model returns res=8, flags 0):
  - `done` occurs 8 cycles after `start`;
  - `vec_count`=1;
  - `sig`=32'hFB3EE241;
  - `pass`=1 with `gold_sig`=32'hFB3EE241.
- **Default parameters** (5×23, Cin sweep off): `vec_count`=115; `sig` equals the bench reference model; flipping `gold_sig` bit 0 → `pass`=0.
- **Cin sweep compiled in:**
  - `vec_count`=230;
  - `alu_cin` alternates 0,1 for consecutive vectors with an identical `alu_op`/`alu_a`/`alu_b`;
  - total time = 5·(4+138)+1 = 711 cycles.
- **Abort:** assert `abort` 20 cycles into a sweep → `busy`=0 next cycle; no `done`; `vec_count` holds at 5 (vectors sampled by cycle 20); a new `start` restarts with the seed.
- **Start while busy:** pulse `start` during SAMPLE → ignored; the sweep completes with the same `sig` and cycle count as an undisturbed run.
